led_matrix_scanner: RTL
=======================

# led_matrix_scanner

- Row-scan controller for the 8x8 LED matrix on Pmod headers JA/JB.
- Takes the 64-bit game map through a valid/ready handshake and double-buffers it.
- Swaps buffers only at frame boundaries, so the displayed image never tears.
- Multiplexes one row at a time, with a blanking gap between rows to suppress ghosting; sits between game logic and the Pmod pins.

## Interface
- DWELL_CYCLES, 100000: clocks each row is lit; ≥8 and a multiple of 8 (1 ms at 100 MHz).
- BLANK_CYCLES, 1000: clocks all columns are off before each row; ≥1.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- map  in  64  frame data; row r = map[8*r+7 : 8*r], bit c = column c, 1 = LED on.
- map_valid  in  1  map holds a new frame.
- map_ready  out  1  pending buffer empty; transfer occurs when map_valid & map_ready.
- JA  out  8  row select, one-hot active-high; JA[r] drives row r.
- JB  out  8  column drive, active-low; JB[c]=0 lights column c.
- frame_start  out  1  one-cycle pulse at the first cycle of row 0 blanking.
- row_idx  out  3  row currently being scanned.

## Operation
- Two 64-bit buffers:
  - disp: the image being scanned.
  - pend: the accepted frame plus a pend_full flag.
  - map_ready = ~pend_full.
- Accept: on map_valid & map_ready, pend <= map and pend_full <= 1.
- FSM states:
  - BLANK: JA=0, JB=8'hFF for BLANK_CYCLES, then go to DRIVE.
  - DRIVE: JA=1<<row, JB=~disp row for DWELL_CYCLES, then go to BLANK with row+1.
  - row wraps 7 -> 0.
- Frame boundary (last DRIVE cycle of row 7):
  - If pend_full: disp <= pend and pend_full <= 0. Row 0 of the next frame shows the new image.
  - If pend_full is 0 at the boundary and an accept happens that same cycle: the data goes into pend only. It is swapped in at the next boundary.
- Accept cannot coincide with a swap, because ready is low while pend is full.
- map_valid without map_ready is ignored. The producer holds map stable until the transfer.
- A single down-counter, reloaded on each state change, sets the phase length.
- Counter width = $clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1).

## Timing
- Reset values:
  - JA=8'h00, JB=8'hFF, row_idx=0, frame_start=0.
  - map_ready=1, disp=0, pend_full=0, state BLANK, counter loaded with BLANK_CYCLES.
- All outputs are registered.
- The first cycle after reset release is BLANK row 0, and frame_start=1 in that cycle.
- Row period = BLANK_CYCLES + DWELL_CYCLES. Frame period = 8 × row period.
- frame_start pulses exactly once per frame.
- map_ready falls in the cycle after an accept.
- map_ready rises in the cycle after the swap, which is the first BLANK cycle of row 0, coincident with frame_start.
- Reset asserted mid-frame forces reset values immediately. An in-flight pend is discarded.

## Configuration
- LED_MATRIX_DIM_EN defined:
  - Adds input bright[2:0], sampled at the frame boundary.
  - In DRIVE, columns are enabled only while elapsed dwell cycles < (bright+1)·DWELL_CYCLES/8. For the remainder, JB=8'hFF.
  - JA stays asserted for the full dwell.
  - Reset brightness is 7.
- Undefined: no bright port; columns are enabled for the full dwell.

## Structure
- Shared package matrix_pkg holds:
  - ROWS=8, COLS=8.
  - The state enum {BLANK, DRIVE}.
  - The row-slice helper function (row r of a 64-bit map).
- One sub-module, matrix_phase_timer: loadable down-counter with a terminal-count flag. The scanner FSM, buffers and output registers live in led_matrix_scanner.

## Test plan
All scenarios use DWELL_CYCLES=8, BLANK_CYCLES=2.
- Reset release, map never sent:
  - JA=00, JB=FF for 2 clocks, then JA=01, JB=FF for 8.
  - frame_start is high on the first cycle; frame period is 80 clocks.
- map=64'h0000_0000_0000_00A5 accepted mid-frame:
  - map_ready low until the next boundary.
  - Row 0 of the following frame has JB=8'h5A, all other rows JB=FF.
- Second map_valid while pend_full: ignored. The first pending frame is displayed, and the second is accepted only after map_ready returns high.
- Accept on the exact last DRIVE cycle of row 7 with pend empty: the new image appears one frame later, not in the immediate next frame.
- rst pulsed during DRIVE of row 4:
  - Outputs return to JA=00, JB=FF, map_ready=1 asynchronously.
  - Scanning restarts at row 0 with a blank display.
- With LED_MATRIX_DIM_EN and bright=1: in each DRIVE phase, JB carries row data for 2 of 8 cycles and is FF for the remaining 6.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared geometry, scan states and row-slice helper for the LED matrix scanner
package matrix_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  typedef enum logic {BLANK, DRIVE} state_t;
  function automatic logic [COLS-1:0] row_of(input logic [ROWS*COLS-1:0] m, input logic [2:0] r);
    return m[COLS*r +: COLS];
  endfunction
endpackage

// File: rtl/matrix_phase_timer.sv
// matrix_phase_timer: loadable down-counter; tc_o marks the last cycle of a phase
module matrix_phase_timer #(
  parameter int CW = 8,
  parameter int RST_VAL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);
  assign tc_o = cnt_o == CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_o <= CW'(RST_VAL);
    else cnt_o <= load_i ? load_val_i : cnt_o - CW'(1);
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered 8x8 row-scan driver with blanking between rows.
// Define LED_MATRIX_DIM_EN to add the frame-sampled bright[2:0] PWM dimming input.
module led_matrix_scanner import matrix_pkg::*; #(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] map,
  input  logic        map_valid,
`ifdef LED_MATRIX_DIM_EN
  input  logic [2:0]  bright,
`endif
  output logic        map_ready,
  output logic [7:0]  JA,
  output logic [7:0]  JB,
  output logic        frame_start,
  output logic [2:0]  row_idx
);
  localparam int CW = $clog2((DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) + 1);
  // state_q/row_q/cnt describe the cycle the output registers will present next
  state_t        state_q;
  logic [2:0]    row_q;
  logic [CW-1:0] cnt;
  logic          tc, fs, accept, swap, lit;
  logic [63:0]   disp_q, pend_q;
  assign fs     = state_q == BLANK && row_q == 3'd0 && cnt == CW'(BLANK_CYCLES);
  assign accept = map_valid & map_ready;
  assign swap   = fs & ~map_ready;
  matrix_phase_timer #(.CW(CW), .RST_VAL(BLANK_CYCLES)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tc),
    .load_val_i (state_q == BLANK ? CW'(DWELL_CYCLES) : CW'(BLANK_CYCLES)),
    .cnt_o      (cnt),
    .tc_o       (tc)
  );
`ifdef LED_MATRIX_DIM_EN
  logic [2:0]  bright_q;
  logic [31:0] elapsed, on_len;
  assign elapsed = 32'(DWELL_CYCLES) - 32'(cnt);
  assign on_len  = (32'(bright_q) + 32'd1) * 32'(DWELL_CYCLES / 8);
  assign lit     = elapsed < on_len;
  always_ff @(posedge clk or posedge rst)
    if (rst) bright_q <= 3'd7;
    else if (fs) bright_q <= bright;
`else
  assign lit = 1'b1;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= BLANK;
      row_q       <= 3'd0;
      disp_q      <= '0;
      pend_q      <= '0;
      map_ready   <= 1'b1;
      JA          <= 8'h00;
      JB          <= 8'hFF;
      frame_start <= 1'b0;
      row_idx     <= 3'd0;
    end else begin
      JA          <= state_q == DRIVE ? 8'd1 << row_q : 8'h00;
      JB          <= state_q == DRIVE && lit ? ~row_of(disp_q, row_q) : 8'hFF;
      frame_start <= fs;
      row_idx     <= row_q;
      if (tc) begin
        state_q <= state_q == BLANK ? DRIVE : BLANK;
        if (state_q == DRIVE) row_q <= row_q + 3'd1;
      end
      if (swap) disp_q <= pend_q;
      if (accept) pend_q <= map;
      map_ready <= swap | (map_ready & ~accept);
    end
endmodule
